// File: rtl/ex_mem_buf.sv
// Execute-to-memory boundary: 2-entry skid buffer with overflow-to-exception conversion.
// Optional macro EX_MEM_OVF_TRAP_EN enables overflow trapping (exc/epc/exc_pending).
module ex_mem_buf #(
  parameter int unsigned N  = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  alures,
  input  logic          ovfalu,
  input  logic [N-1:0]  in_pc,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_res,
  output logic [N-1:0]  out_pc,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic          exc,
  output logic [N-1:0]  epc
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_in_ready;
  logic          r_exc_pending;
  logic          w_pend_nxt;
  logic          r_exc;
  logic [N-1:0]  r_epc;

  logic [N-1:0]  r_head_res;
  logic [N-1:0]  r_head_pc;
  logic [RW-1:0] r_head_rd;
  logic          r_head_we;
  logic          r_head_exc;
  logic [N-1:0]  r_skid_res;
  logic [N-1:0]  r_skid_pc;
  logic [RW-1:0] r_skid_rd;
  logic          r_skid_we;
  logic          r_skid_exc;

  logic          w_ovf;
  logic          w_in_we;
  logic          w_enq;
  logic          w_deq;
  logic          w_ld_head_in;
  logic          w_ld_head_skid;
  logic          w_ld_skid;
  logic          w_in_ready_nxt;
  logic          w_exc_nxt;

`ifdef EX_MEM_OVF_TRAP_EN
  assign w_ovf = ovfalu;
`else
  // Overflow is ignored entirely when trapping is compiled out.
  logic w_unused_ovf;
  assign w_unused_ovf = ovfalu;
  assign w_ovf = 1'b0;
`endif

  // Register 0 is never written; a faulting instruction never writes back.
  assign w_in_we = in_we && !w_ovf && (in_rd != RW'(0));

  assign w_enq = in_valid && r_in_ready;
  assign w_deq = (r_state != ST_EMPTY) && out_ready;

  // Next-state, load-select and handshake decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_exc_pending;
    w_ld_head_in   = 1'b0;
    w_ld_head_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_pend_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_enq) begin
            w_state_nxt  = ST_HALF;
            w_ld_head_in = 1'b1;
          end
        end
        ST_HALF: begin
          if (w_enq && w_deq) begin
            w_ld_head_in = 1'b1;
          end else if (w_enq) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_deq) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_deq) begin
            w_state_nxt    = ST_HALF;
            w_ld_head_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
      if (w_enq && w_ovf) begin
        w_pend_nxt = 1'b1;
      end
    end
    w_in_ready_nxt = (w_state_nxt != ST_FULL) && !w_pend_nxt;
    // A flagged dequeue still raises exc even under flush.
    w_exc_nxt      = w_deq && r_head_exc;
  end

  // State, handshake and exception registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_EMPTY;
      r_in_ready    <= 1'b0;
      r_exc_pending <= 1'b0;
      r_exc         <= 1'b0;
      r_epc         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_exc_pending <= w_pend_nxt;
      r_exc         <= w_exc_nxt;
      if (w_exc_nxt) begin
        r_epc <= r_head_pc;
      end
    end
  end

  // Head and skid entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head_res <= '0;
      r_head_pc  <= '0;
      r_head_rd  <= '0;
      r_head_we  <= 1'b0;
      r_head_exc <= 1'b0;
      r_skid_res <= '0;
      r_skid_pc  <= '0;
      r_skid_rd  <= '0;
      r_skid_we  <= 1'b0;
      r_skid_exc <= 1'b0;
    end else begin
      if (w_ld_head_in) begin
        r_head_res <= alures;
        r_head_pc  <= in_pc;
        r_head_rd  <= in_rd;
        r_head_we  <= w_in_we;
        r_head_exc <= w_ovf;
      end else if (w_ld_head_skid) begin
        r_head_res <= r_skid_res;
        r_head_pc  <= r_skid_pc;
        r_head_rd  <= r_skid_rd;
        r_head_we  <= r_skid_we;
        r_head_exc <= r_skid_exc;
      end
      if (w_ld_skid) begin
        r_skid_res <= alures;
        r_skid_pc  <= in_pc;
        r_skid_rd  <= in_rd;
        r_skid_we  <= w_in_we;
        r_skid_exc <= w_ovf;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_res   = r_head_res;
  assign out_pc    = r_head_pc;
  assign out_rd    = r_head_rd;
  assign out_we    = r_head_we;
  assign exc       = r_exc;
  assign epc       = r_epc;

endmodule

// File: tb/tb_ex_mem_buf.sv
// Directed self-checking bench for ex_mem_buf (both EX_MEM_OVF_TRAP_EN builds).
module tb_ex_mem_buf;

  localparam int unsigned N  = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  alures;
  logic          ovfalu;
  logic [N-1:0]  in_pc;
  logic [RW-1:0] in_rd;
  logic          in_we;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_res;
  logic [N-1:0]  out_pc;
  logic [RW-1:0] out_rd;
  logic          out_we;
  logic          exc;
  logic [N-1:0]  epc;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_buf #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alures(alures), .ovfalu(ovfalu), .in_pc(in_pc), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_pc(out_pc), .out_rd(out_rd), .out_we(out_we),
    .exc(exc), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [N-1:0] res, input logic [N-1:0] pc,
                       input logic [RW-1:0] rd, input logic we, input logic ovf);
    in_valid = 1'b1;
    alures   = res;
    in_pc    = pc;
    in_rd    = rd;
    in_we    = we;
    ovfalu   = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); n_fail++; end
    n_checks++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready: got %b want 0", in_ready); n_fail++; end
    n_checks++; if (out_res !== 32'h0 || out_pc !== 32'h0 || out_rd !== 5'd0 || out_we !== 1'b0) begin
      $display("FAIL reset_outs: got res=%h pc=%h rd=%0d we=%b want all 0", out_res, out_pc, out_rd, out_we); n_fail++; end
    n_checks++; if (exc !== 1'b0 || epc !== 32'h0) begin $display("FAIL reset_exc: got exc=%b epc=%h want 0/0", exc, epc); n_fail++; end
    rst_n = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1) begin $display("FAIL post_reset_in_ready: got %b want 1", in_ready); n_fail++; end
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL post_reset_out_valid: got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    offer(32'h0000_0005, 32'h0000_0100, 5'd3, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin $display("FAIL single_valid: got %b want 1", out_valid); n_fail++; end
    n_checks++; if (out_res !== 32'h5 || out_we !== 1'b1 || out_rd !== 5'd3 || out_pc !== 32'h100) begin
      $display("FAIL single_data: got res=%h we=%b rd=%0d pc=%h want 5/1/3/100", out_res, out_we, out_rd, out_pc); n_fail++; end
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL single_drain: got valid=%b ready=%b want 0/1", out_valid, in_ready); n_fail++; end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'(10 + i), 32'(32'h200 + 4 * i), 5'd7, 1'b1, 1'b0);
      step();
      n_checks++; if (out_valid !== 1'b1 || out_res !== 32'(10 + i) || in_ready !== 1'b1) begin
        $display("FAIL b2b_%0d: got valid=%b res=%h ready=%b want 1/%h/1", i, out_valid, out_res, in_ready, 32'(10 + i)); n_fail++; end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL b2b_drain: got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(32'h1, 32'h300, 5'd1, 1'b1, 1'b0);
    step();
    n_checks++; if (out_res !== 32'h1 || in_ready !== 1'b1) begin
      $display("FAIL bp_first: got res=%h ready=%b want 1/1", out_res, in_ready); n_fail++; end
    offer(32'h2, 32'h304, 5'd2, 1'b1, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== 32'h1) begin
      $display("FAIL bp_full: got ready=%b valid=%b res=%h want 0/1/1", in_ready, out_valid, out_res); n_fail++; end
    offer(32'h3, 32'h308, 5'd3, 1'b1, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b0 || out_res !== 32'h1) begin
      $display("FAIL bp_hold: got ready=%b res=%h want 0/1", in_ready, out_res); n_fail++; end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_res !== 32'h2 || out_pc !== 32'h304 || in_ready !== 1'b1) begin
      $display("FAIL bp_second: got valid=%b res=%h pc=%h ready=%b want 1/2/304/1", out_valid, out_res, out_pc, in_ready); n_fail++; end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_res !== 32'h3) begin
      $display("FAIL bp_third: got valid=%b res=%h want 1/3", out_valid, out_res); n_fail++; end
    step();
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL bp_drain: got %b want 0", out_valid); n_fail++; end
  endtask

  task automatic test_rd_zero();
    out_ready = 1'b1;
    offer(32'h77, 32'h400, 5'd0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_res !== 32'h77) begin
      $display("FAIL rd_zero: got valid=%b we=%b res=%h want 1/0/77", out_valid, out_we, out_res); n_fail++; end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(32'hA, 32'h500, 5'd1, 1'b1, 1'b0);
    step();
    offer(32'hB, 32'h504, 5'd2, 1'b1, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b0) begin $display("FAIL flush_full: got ready=%b want 0", in_ready); n_fail++; end
    offer(32'hC, 32'h508, 5'd3, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_now: got valid=%b ready=%b want 0/1", out_valid, in_ready); n_fail++; end
    step();
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_dropped: got valid=%b res=%h want 0", out_valid, out_res); n_fail++; end
  endtask

`ifdef EX_MEM_OVF_TRAP_EN
  task automatic test_ovf();
    out_ready = 1'b0;
    offer(32'h99, 32'h0040_0010, 5'd5, 1'b1, 1'b1);
    step();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_we !== 1'b0 || exc !== 1'b0) begin
      $display("FAIL ovf_accept: got ready=%b valid=%b we=%b exc=%b want 0/1/0/0", in_ready, out_valid, out_we, exc); n_fail++; end
    offer(32'h55, 32'h0040_0014, 5'd6, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    n_checks++; if (exc !== 1'b1 || epc !== 32'h0040_0010) begin
      $display("FAIL ovf_exc: got exc=%b epc=%h want 1/00400010", exc, epc); n_fail++; end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL ovf_block: got valid=%b ready=%b want 0/0", out_valid, in_ready); n_fail++; end
    step();
    n_checks++; if (exc !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL ovf_pulse: got exc=%b valid=%b ready=%b want 0/0/0", exc, out_valid, in_ready); n_fail++; end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || epc !== 32'h0040_0010) begin
      $display("FAIL ovf_flush: got ready=%b valid=%b epc=%h want 1/0/00400010", in_ready, out_valid, epc); n_fail++; end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_res !== 32'h55 || out_pc !== 32'h0040_0014 || out_we !== 1'b1) begin
      $display("FAIL ovf_resume: got valid=%b res=%h pc=%h we=%b want 1/55/00400014/1", out_valid, out_res, out_pc, out_we); n_fail++; end
    step();
  endtask
`else
  task automatic test_ovf();
    out_ready = 1'b1;
    offer(32'h9, 32'h0040_0010, 5'd4, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    ovfalu   = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_we !== 1'b1 || out_rd !== 5'd4 || in_ready !== 1'b1 || exc !== 1'b0) begin
      $display("FAIL ovf_ignored: got valid=%b we=%b rd=%0d ready=%b exc=%b want 1/1/4/1/0", out_valid, out_we, out_rd, in_ready, exc); n_fail++; end
    step();
    n_checks++; if (exc !== 1'b0 || epc !== 32'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL ovf_no_exc: got exc=%b epc=%h ready=%b valid=%b want 0/0/1/0", exc, epc, in_ready, out_valid); n_fail++; end
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alures = '0; ovfalu = 1'b0;
    in_pc = '0; in_rd = '0; in_we = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_rd_zero();
    test_flush();
    test_ovf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
